button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Front end for the stopwatch push-buttons (start, stop, midstop). Each raw
//  button is synchronised to clk100MHz, debounced, and turned into one press
//  event. Press events are arbitrated and stretched so the 100 Hz counter
//  domain samples every press exactly once. Outputs drive counter start/stop/midstop.
// PARAMETERS
//  SYNC_STAGES      2          flip-flops in each input synchroniser (>=2)
//  DEBOUNCE_CYCLES  2_000_000  consecutive stable cycles needed to accept a level (20 ms)
//  PULSE_CYCLES     1_000_000  clk100MHz cycles each press output stays high (10 ms)
// PORTS
//  clk100MHz    in   1  main clock, posedge active
//  rst_n        in   1  asynchronous reset, active LOW
//  start_raw    in   1  raw start button, asynchronous, bouncing
//  stop_raw     in   1  raw stop button, asynchronous, bouncing
//  midstop_raw  in   1  raw midstop button, asynchronous, bouncing
//  start        out  1  stretched start press, to counter
//  stop         out  1  stretched stop press, to counter
//  midstop      out  1  stretched midstop press, to counter
//  btn_level    out  3  debounced levels {midstop,stop,start}
// BEHAVIOUR
//  Reset (rst_n=0, async): sync FFs, levels, counters 0; FSMs in LOW; all outputs 0.
//  Channel FSM (per button, on synced input s):
//   LOW      : s=1 -> ARM_HI, cnt=1;                 else stay
//   ARM_HI   : s=0 -> LOW, cnt=0; cnt==DEBOUNCE_CYCLES -> HIGH + press event; else cnt++
//   HIGH     : s=0 -> ARM_LO, cnt=1;                 else stay
//   ARM_LO   : s=1 -> HIGH, cnt=0; cnt==DEBOUNCE_CYCLES -> LOW;  else cnt++
//   Any glitch during ARM_* aborts back to the prior stable state; no event.
//   Counter width $clog2(DEBOUNCE_CYCLES+1); no wrap possible.
//   btn_level bit =1 in HIGH and ARM_LO, 0 in LOW and ARM_HI (registered).
//  Press event: one-cycle internal strobe on ARM_HI->HIGH only (release: none).
//  Latency: raw edge held stable -> output rises SYNC_STAGES+DEBOUNCE_CYCLES+1 edges later.
//  Button held through reset release: treated as a new press (stable level resets to 0).
//  Arbiter/stretcher (single, shared):
//   priority stop > midstop > start for events in the same cycle;
//   at most one of start/stop/midstop high at any time (one-hot or zero);
//   idle + event -> assert winner output, load pcnt=PULSE_CYCLES;
//   active: pcnt-- each cycle, output drops when pcnt reaches 0 (high exactly
//   PULSE_CYCLES cycles); event of higher priority than active output
//   preempts: switch output, reload pcnt; equal/lower priority event dropped.
//   Output changes are registered (glitch-free into the 100 Hz domain).
//  Reset mid-pulse or mid-debounce: outputs fall asynchronously, state cleared.
// TESTING  (bench params: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PULSE_CYCLES=3)
//  1 clean press: start_raw 0->1 held 20 cyc -> start=1 on edge 7 after change,
//    high exactly 3 cycles; btn_level[0]=1; stop,midstop stay 0.
//  2 bounce: start_raw toggles 1,0,1,0 every 2 cyc then stays 1 -> single start
//    pulse, 7 edges after final rise; release bounce -> no pulse.
//  3 short glitch: stop_raw high 3 cycles only -> no output, btn_level stays 0.
//  4 simultaneous: start_raw,stop_raw rise same cycle -> only stop pulses (3 cyc);
//    start dropped; outputs never overlap.
//  5 preemption: start pulse active, stop press event on its 2nd cycle -> start
//    falls, stop high 3 cycles next edge; midstop event during stop -> dropped.
//  6 reset: rst_n low mid-pulse and mid-ARM_HI -> outputs 0 immediately; button
//    held through release -> one press pulse 7 edges after rst_n rises.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Raw push-button inputs and conditioned press/level outputs of the stopwatch button front end.
interface button_conditioner_if;
  logic       start_raw;
  logic       stop_raw;
  logic       midstop_raw;
  logic       start;
  logic       stop;
  logic       midstop;
  logic [2:0] btn_level;

  modport master (
    output start_raw, stop_raw, midstop_raw,
    input  start, stop, midstop, btn_level
  );

  modport slave (
    input  start_raw, stop_raw, midstop_raw,
    output start, stop, midstop, btn_level
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises, debounces and arbitrates the three stopwatch buttons into stretched,
// mutually exclusive press pulses suitable for sampling by the slow counter domain.
module button_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned PULSE_CYCLES    = 1_000_000
) (
  input logic                  clk100MHz,
  input logic                  rst_n,
  button_conditioner_if.slave  bus
);

  localparam int unsigned N_BTN = 3;
  localparam int unsigned CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PW    = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [1:0] {LOW, ARM_HI, HIGH, ARM_LO} deb_state_t;
  // Encoding doubles as priority rank: a larger value preempts a smaller one.
  typedef enum logic [1:0] {IDLE, ACT_START, ACT_MIDSTOP, ACT_STOP} arb_state_t;

  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] press_c;
  logic [N_BTN-1:0] level_vec;

  assign raw = {bus.midstop_raw, bus.stop_raw, bus.start_raw};

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press;

    assign s = sync_q[SYNC_STAGES-1];

    // Input synchroniser, debounce state, counter and level register.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '0;
        state_q <= LOW;
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], raw[g]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    // A level is accepted only after staying stable; any glitch returns to the prior level.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press   = 1'b0;
      unique case (state_q)
        LOW: begin
          if (s) begin
            state_d = ARM_HI;
            cnt_d   = CW'(1);
          end
        end
        ARM_HI: begin
          if (!s) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
            state_d = HIGH;
            cnt_d   = '0;
            press   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HIGH: begin
          if (!s) begin
            state_d = ARM_LO;
            cnt_d   = CW'(1);
          end
        end
        ARM_LO: begin
          if (s) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
            state_d = LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
      level_d = (state_d == HIGH) || (state_d == ARM_LO);
    end

    assign press_c[g]   = press;
    assign level_vec[g] = level_q;
  end

  arb_state_t      arb_q, arb_d, winner_c;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [N_BTN-1:0] out_q, out_d;

  // Same-cycle priority: stop > midstop > start.
  always_comb begin
    winner_c = IDLE;
    if (press_c[1])      winner_c = ACT_STOP;
    else if (press_c[2]) winner_c = ACT_MIDSTOP;
    else if (press_c[0]) winner_c = ACT_START;
  end

  // Stretcher: load on a higher-rank event, otherwise count the active pulse down.
  always_comb begin
    arb_d  = arb_q;
    pcnt_d = pcnt_q;
    if (winner_c > arb_q) begin
      arb_d  = winner_c;
      pcnt_d = PW'(PULSE_CYCLES);
    end else if (arb_q != IDLE) begin
      if (pcnt_q == PW'(1)) arb_d = IDLE;
      pcnt_d = pcnt_q - PW'(1);
    end
    out_d = {arb_d == ACT_MIDSTOP, arb_d == ACT_STOP, arb_d == ACT_START};
  end

  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      arb_q  <= IDLE;
      pcnt_q <= '0;
      out_q  <= '0;
    end else begin
      arb_q  <= arb_d;
      pcnt_q <= pcnt_d;
      out_q  <= out_d;
    end
  end

  assign bus.start     = out_q[0];
  assign bus.stop      = out_q[1];
  assign bus.midstop   = out_q[2];
  assign bus.btn_level = level_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed plus randomized bench for button_conditioner against a run-length reference model.
module tb_button_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int PUL  = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  button_conditioner_if bus ();

  button_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PUL)
  ) dut (
    .clk100MHz(clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: delayed samples, per-button disagreement run, accepted levels, active pulse.
  logic [2:0] mq[$];
  int         run[3];
  logic [2:0] m_lvl;
  int         m_act;
  int         m_rem;
  logic [2:0] exp_out;

  function automatic logic [2:0] outs();
    return {bus.midstop, bus.stop, bus.start};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    mq = {};
    for (int i = 0; i < SYNC; i++) mq.push_back(3'b000);
    for (int i = 0; i < 3; i++) run[i] = 0;
    m_lvl   = 3'b000;
    m_act   = 0;
    m_rem   = 0;
    exp_out = 3'b000;
  endtask

  // One clock edge of the specification: level flips after DEB+1 consecutive disagreeing samples.
  task automatic model_edge(input logic [2:0] r);
    logic [2:0] s;
    logic [2:0] ev;
    int         win;
    s  = mq.pop_front();
    mq.push_back(r);
    ev = 3'b000;
    for (int ch = 0; ch < 3; ch++) begin
      if (s[2'(ch)] !== m_lvl[2'(ch)]) begin
        run[ch]++;
        if (run[ch] == DEB + 1) begin
          m_lvl[2'(ch)] = s[2'(ch)];
          ev[2'(ch)]    = s[2'(ch)];
          run[ch]       = 0;
        end
      end else begin
        run[ch] = 0;
      end
    end
    win = ev[1] ? 3 : ev[2] ? 2 : ev[0] ? 1 : 0;
    if (win > m_act) begin
      m_act = win;
      m_rem = PUL;
    end else if (m_act != 0) begin
      m_rem--;
      if (m_rem == 0) m_act = 0;
    end
    exp_out = (m_act == 3) ? 3'b010 : (m_act == 2) ? 3'b100 : (m_act == 1) ? 3'b001 : 3'b000;
  endtask

  // Drive raw {midstop,stop,start} at a negedge, clock once, compare at the next negedge.
  task automatic cycle(input logic [2:0] r);
    bus.start_raw   = r[0];
    bus.stop_raw    = r[1];
    bus.midstop_raw = r[2];
    @(posedge clk);
    if (rst_n) model_edge(r);
    else       model_reset();
    @(negedge clk);
    chk("outs",   32'(outs()), 32'(exp_out));
    chk("level",  32'(bus.btn_level), 32'(m_lvl));
    chk("onehot", 32'($onehot0(outs())), 32'd1);
  endtask

  task automatic reset_pulse(input logic [2:0] r, input int hold);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_outs",  32'(outs()), 32'd0);
    chk("rst_async_level", 32'(bus.btn_level), 32'd0);
    @(negedge clk);
    for (int i = 0; i < hold; i++) cycle(r);
    rst_n = 1'b1;
  endtask

  initial begin
    int rise;
    int hi_s, hi_p, hi_m;
    int pulses;
    logic [2:0] seen;
    logic [2:0] r;
    int hold[3];

    rst_n           = 1'b0;
    bus.start_raw   = 1'b0;
    bus.stop_raw    = 1'b0;
    bus.midstop_raw = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_outs",  32'(outs()), 32'd0);
    chk("reset_level", 32'(bus.btn_level), 32'd0);
    cycle(3'b000);
    rst_n = 1'b1;
    repeat (4) cycle(3'b000);

    // 1: clean press, latency and width
    rise = -1; hi_s = 0; seen = 3'b000;
    for (int i = 1; i <= 20; i++) begin
      cycle(3'b001);
      if (bus.start && rise < 0) rise = i;
      if (bus.start) hi_s++;
      seen |= {bus.midstop, bus.stop, 1'b0};
    end
    chk("t1_latency", 32'(rise), 32'd7);
    chk("t1_width",   32'(hi_s), 32'd3);
    chk("t1_level",   32'(bus.btn_level), 32'd1);
    chk("t1_others",  32'(seen), 32'd0);
    repeat (20) cycle(3'b000);

    // 2: bouncing press then bouncing release
    for (int k = 0; k < 4; k++) repeat (2) cycle((k % 2 == 0) ? 3'b001 : 3'b000);
    rise = -1; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(3'b001);
      if (bus.start && rise < 0) rise = i;
      if (bus.start) pulses++;
    end
    chk("t2_latency", 32'(rise), 32'd7);
    chk("t2_width",   32'(pulses), 32'd3);
    hi_s = 0;
    for (int k = 0; k < 4; k++) repeat (2) cycle((k % 2 == 0) ? 3'b000 : 3'b001);
    for (int i = 0; i < 20; i++) begin
      cycle(3'b000);
      if (bus.start) hi_s++;
    end
    chk("t2_release_none", 32'(hi_s), 32'd0);
    chk("t2_level_low",    32'(bus.btn_level), 32'd0);

    // 3: short glitch on stop
    seen = 3'b000;
    repeat (3) begin cycle(3'b010); seen |= outs() | bus.btn_level; end
    repeat (15) begin cycle(3'b000); seen |= outs() | bus.btn_level; end
    chk("t3_glitch", 32'(seen), 32'd0);

    // 4: simultaneous start and stop
    hi_s = 0; hi_p = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(3'b011);
      if (bus.start) hi_s++;
      if (bus.stop)  hi_p++;
    end
    chk("t4_start_dropped", 32'(hi_s), 32'd0);
    chk("t4_stop_width",    32'(hi_p), 32'd3);
    repeat (20) cycle(3'b000);

    // 5: stop preempts start, midstop during stop dropped
    hi_s = 0; hi_p = 0; hi_m = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle((i >= 4) ? 3'b111 : (i >= 3) ? 3'b011 : 3'b001);
      if (bus.start)   hi_s++;
      if (bus.stop)    hi_p++;
      if (bus.midstop) hi_m++;
    end
    chk("t5_start_cut",    32'(hi_s), 32'd2);
    chk("t5_stop_width",   32'(hi_p), 32'd3);
    chk("t5_midstop_drop", 32'(hi_m), 32'd0);
    repeat (20) cycle(3'b000);

    // 6: reset mid-pulse with button held, then reset mid-debounce
    repeat (8) cycle(3'b010);
    chk("t6_pulse_active", 32'(bus.stop), 32'd1);
    reset_pulse(3'b010, 2);
    rise = -1;
    for (int i = 1; i <= 12; i++) begin
      cycle(3'b010);
      if (bus.stop && rise < 0) rise = i;
    end
    chk("t6_held_latency", 32'(rise), 32'd7);
    repeat (20) cycle(3'b000);
    repeat (4) cycle(3'b001);
    reset_pulse(3'b001, 1);
    repeat (12) cycle(3'b001);
    repeat (20) cycle(3'b000);

    // Randomized bouncing on all three buttons
    r = 3'b000;
    for (int c = 0; c < 3; c++) hold[c] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          r[2'(c)] = 1'($urandom_range(0, 1));
          hold[c]  = int'($urandom_range(1, 12));
        end
        hold[c]--;
      end
      cycle(r);
    end
    repeat (20) cycle(3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
